// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for one AES-128 block.
// Drives the key scheduler handshake (ks_en/ks_ry/sel_key) and the round
// datapath strobes (load_data, rnd_en, mix_en). The round-key schedule is
// cached: it is regenerated only when new_key is given with start, or when no
// valid schedule exists (after reset or a scheduler timeout).
// Optional feature: define AES_DECRYPT_EN to add the 'mode' input
// (0 = encrypt, 1 = decrypt), which reverses the round-key order.
module aes_round_ctrl #(
  parameter int NR         = 10,
  parameter int KS_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       new_key,
`ifdef AES_DECRYPT_EN
  input  logic       mode,
`endif
  input  logic       ks_ry,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ks_en,
  output logic [3:0] sel_key,
  output logic       load_data,
  output logic       rnd_en,
  output logic       mix_en
);

  // The round counter is 4 bits wide, so more than 15 rounds cannot be encoded.
  if (NR < 1 || NR > 15) begin : g_bad_nr
    $error("aes_round_ctrl: NR must be in the range 1..15");
  end
  if (KS_TIMEOUT < 1) begin : g_bad_tmo
    $error("aes_round_ctrl: KS_TIMEOUT must be at least 1");
  end

  localparam logic [3:0] NR_L = 4'(NR);
  // The timeout counter only needs to reach KS_TIMEOUT-1.
  localparam int TW = (KS_TIMEOUT < 2) ? 1 : $clog2(KS_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(KS_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYGEN = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [3:0]    rnd_reg, rnd_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          key_valid_reg, key_valid_next;
  logic          mode_reg, mode_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          ks_en_reg, ks_en_next;
  logic [3:0]    sel_key_reg, sel_key_next;
  logic          load_reg, load_next;
  logic          rnd_en_reg, rnd_en_next;
  logic          mix_en_reg, mix_en_next;

  logic          mode_in;
  logic [3:0]    rnd_inc;
  logic          init_go;
  logic          init_dec;

`ifdef AES_DECRYPT_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b0;
`endif

  assign rnd_inc = rnd_reg + 4'd1;

  // Round-key index for round r: ascending for encrypt, descending for decrypt.
  function automatic logic [3:0] key_sel(input logic dec, input logic [3:0] r);
    return dec ? (NR_L - r) : r;
  endfunction

  // Next-state and next-output decode; every strobe is computed one cycle
  // ahead so the outputs come straight from flops.
  always_comb begin
    state_next     = state_reg;
    rnd_next       = rnd_reg;
    tmo_next       = tmo_reg;
    key_valid_next = key_valid_reg;
    mode_next      = mode_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = err_reg;
    ks_en_next     = 1'b0;
    sel_key_next   = sel_key_reg;
    load_next      = 1'b0;
    rnd_en_next    = 1'b0;
    mix_en_next    = 1'b0;
    init_go        = 1'b0;
    init_dec       = mode_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          busy_next = 1'b1;
          err_next  = 1'b0;
          mode_next = mode_in;
          if (new_key || !key_valid_reg) begin
            state_next = S_KEYGEN;
            ks_en_next = 1'b1;
            tmo_next   = '0;
          end else begin
            init_go  = 1'b1;
            init_dec = mode_in;
          end
        end
      end
      S_KEYGEN: begin
        if (ks_ry) begin
          key_valid_next = 1'b1;
          init_go        = 1'b1;
        end else if (tmo_reg == TMO_LAST) begin
          // Scheduler never answered: abandon the block without a done pulse.
          state_next     = S_IDLE;
          err_next       = 1'b1;
          key_valid_next = 1'b0;
          busy_next      = 1'b0;
        end else begin
          tmo_next   = tmo_reg + 1'b1;
          ks_en_next = 1'b1;
        end
      end
      S_INIT, S_ROUND: begin
        // INIT leaves rnd_reg at 0, so both states advance to round rnd_reg+1.
        rnd_en_next = 1'b1;
        if (rnd_inc == NR_L) begin
          state_next   = S_FINAL;
          mix_en_next  = 1'b0;
          sel_key_next = key_sel(mode_reg, NR_L);
        end else begin
          state_next   = S_ROUND;
          mix_en_next  = 1'b1;
          rnd_next     = rnd_inc;
          sel_key_next = key_sel(mode_reg, rnd_inc);
        end
      end
      S_FINAL: begin
        state_next = S_DONE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // INIT cycle: load plaintext and apply the whitening key only.
    if (init_go) begin
      state_next   = S_INIT;
      rnd_next     = 4'd0;
      load_next    = 1'b1;
      rnd_en_next  = 1'b1;
      mix_en_next  = 1'b0;
      sel_key_next = key_sel(init_dec, 4'd0);
    end
  end

  // State and output registers; reset forgets the cached key schedule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rnd_reg       <= 4'd0;
      tmo_reg       <= '0;
      key_valid_reg <= 1'b0;
      mode_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      ks_en_reg     <= 1'b0;
      sel_key_reg   <= 4'd0;
      load_reg      <= 1'b0;
      rnd_en_reg    <= 1'b0;
      mix_en_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rnd_reg       <= rnd_next;
      tmo_reg       <= tmo_next;
      key_valid_reg <= key_valid_next;
      mode_reg      <= mode_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      ks_en_reg     <= ks_en_next;
      sel_key_reg   <= sel_key_next;
      load_reg      <= load_next;
      rnd_en_reg    <= rnd_en_next;
      mix_en_reg    <= mix_en_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign ks_en     = ks_en_reg;
  assign sel_key   = sel_key_reg;
  assign load_data = load_reg;
  assign rnd_en    = rnd_en_reg;
  assign mix_en    = mix_en_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: scoreboard of expected round/done/error
// events with their exact cycle numbers, checked by a separate monitor.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       new_key;
`ifdef AES_DECRYPT_EN
  logic       mode;
`endif
  logic       ks_ry;
  logic       busy, done, err, ks_en, load_data, rnd_en, mix_en;
  logic [3:0] sel_key;

  aes_round_ctrl #(.NR(10), .KS_TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .new_key   (new_key),
`ifdef AES_DECRYPT_EN
    .mode      (mode),
`endif
    .ks_ry     (ks_ry),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ks_en     (ks_en),
    .sel_key   (sel_key),
    .load_data (load_data),
    .rnd_en    (rnd_en),
    .mix_en    (mix_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = round strobe, 1 = done, 2 = error rise
    int at;     // cycle number the event must appear in
    int sel;
    bit mix;
    bit load;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ks_lat   = 0;   // scheduler answers on the ks_lat-th ks_en cycle; 0 = never
  int ks_total = 0;
  int done_cnt = 0;

  // Hand-written round tables for NR = 10 (index 0 = INIT, 10 = FINAL).
  int enc_sel[11]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int dec_sel[11]  = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  bit mix_tab[11]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit load_tab[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected events of a block whose start was high in cycle t, with k keygen cycles.
  task automatic push_block(input int t, input int k, input bit dec);
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      e.kind = 0;
      e.at   = t + k + 1 + i;
      e.sel  = dec ? dec_sel[i] : enc_sel[i];
      e.mix  = mix_tab[i];
      e.load = load_tab[i];
      q.push_back(e);
    end
    e.kind = 1; e.at = t + k + 12; e.sel = 0; e.mix = 0; e.load = 0;
    q.push_back(e);
  endtask

  task automatic push_err(input int at);
    exp_t e;
    e.kind = 2; e.at = at; e.sel = 0; e.mix = 0; e.load = 0;
    q.push_back(e);
  endtask

  // Monitor-side comparison of one observed event against the queue head.
  task automatic check_event(input int kind);
    exp_t e;
    bit ok;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d cycle=%0d sel=%0d mix=%0b load=%0b, expected no event",
               kind, cyc, sel_key, mix_en, load_data);
      return;
    end
    e = q.pop_front();
    case (kind)
      0: ok = (e.kind == 0) && (e.at == cyc) && rnd_en && (int'(sel_key) == e.sel) &&
              (mix_en == e.mix) && (load_data == e.load);
      1: ok = (e.kind == 1) && (e.at == cyc) && !busy && !rnd_en;
      default: ok = (e.kind == 2) && (e.at == cyc) && !busy && !done;
    endcase
    if (!ok) begin
      n_fail++;
      $display("FAIL event: got kind=%0d cycle=%0d rnd=%0b sel=%0d mix=%0b load=%0b busy=%0b, expected kind=%0d cycle=%0d sel=%0d mix=%0b load=%0b",
               kind, cyc, rnd_en, sel_key, mix_en, load_data, busy, e.kind, e.at, e.sel, e.mix, e.load);
    end
    if (kind == 1) $display("done   cycle=%0d", cyc);
    if (kind == 2) $display("error  cycle=%0d", cyc);
  endtask

  // Monitor: sample away from the active edge and match observed events.
  initial begin
    bit err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rnd_en || load_data || mix_en) check_event(0);
        if (done) begin
          done_cnt++;
          check_event(1);
        end
        if (err && !err_prev) check_event(2);
      end
      err_prev = err;
    end
  end

  // Key scheduler model: ready after ks_lat cycles of ks_en.
  initial begin
    int ks_cnt = 0;
    ks_ry = 1'b0;
    forever begin
      @(negedge clk);
      if (ks_en) begin
        ks_cnt++;
        ks_total++;
      end else begin
        ks_cnt = 0;
      end
      ks_ry = (ks_lat != 0) && ks_en && (ks_cnt == ks_lat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  // Start pulse in cycle t; returns one cycle later (cycle t+1).
  task automatic issue(input bit nk, input bit md, output int t);
    step();
    start   = 1'b1;
    new_key = nk;
`ifdef AES_DECRYPT_EN
    mode    = md;
`endif
    t = cyc;
    $display("start  cycle=%0d new_key=%0b mode=%0b ks_lat=%0d", t, nk, md, ks_lat);
    step();
    start   = 1'b0;
    new_key = 1'b0;
`ifdef AES_DECRYPT_EN
    mode    = 1'b0;
`endif
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) step();
    chk(name, q.size(), 0);
    repeat (16) step();
  endtask

  function automatic int outs();
    return {busy, done, err, ks_en, sel_key, load_data, rnd_en, mix_en};
  endfunction

  initial begin
    int t, k0, d0;
    int pulses[3] = '{3, 6, 12};
    rst = 1'b1; start = 1'b0; new_key = 1'b0;
`ifdef AES_DECRYPT_EN
    mode = 1'b0;
`endif
    repeat (3) step();
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (2) step();
    chk("idle_outputs", outs(), 0);

    // First block after reset: key schedule must be generated (5 cycles).
    ks_lat = 5; k0 = ks_total;
    issue(1'b0, 1'b0, t);
    push_block(t, 5, 1'b0);
    chk("busy_after_start", busy, 1);
    chk("ks_en_after_start", ks_en, 1);
    drain("drain_regen");
    chk("regen_ks_cycles", ks_total - k0, 5);

    // Cached schedule: no keygen, done 12 cycles after start.
    k0 = ks_total;
    issue(1'b0, 1'b0, t);
    push_block(t, 0, 1'b0);
    chk("cached_no_ks_en", ks_en, 0);
    drain("drain_cached");
    chk("cached_ks_cycles", ks_total - k0, 0);
    chk("sel_key_held_idle", sel_key, 10);

    // Start pulses while busy and in the done cycle are ignored.
    d0 = done_cnt;
    issue(1'b0, 1'b0, t);
    push_block(t, 0, 1'b0);
    foreach (pulses[i]) begin
      goto_cyc(t + pulses[i]);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    drain("drain_pulses");
    chk("single_done", done_cnt - d0, 1);
    chk("busy_idle_after", busy, 0);

    // Reset during round 4 clears outputs at once and forgets the key.
    issue(1'b0, 1'b0, t);
    push_block(t, 0, 1'b0);
    goto_cyc(t + 5);
    chk("round4_sel_key", sel_key, 4);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", outs(), 0);
    q.delete();
    step();
    rst = 1'b0;
    repeat (2) step();
    ks_lat = 3; k0 = ks_total;
    issue(1'b0, 1'b0, t);
    push_block(t, 3, 1'b0);
    chk("post_reset_keygen", ks_en, 1);
    drain("drain_post_reset");
    chk("post_reset_ks_cycles", ks_total - k0, 3);

    // Scheduler never ready: error after 64 ks_en cycles, no done.
    ks_lat = 0; k0 = ks_total; d0 = done_cnt;
    issue(1'b1, 1'b0, t);
    push_err(t + 65);
    drain("drain_timeout");
    chk("timeout_ks_cycles", ks_total - k0, 64);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_done", done_cnt - d0, 0);
    ks_lat = 2; k0 = ks_total;
    issue(1'b0, 1'b0, t);
    push_block(t, 2, 1'b0);
    chk("err_cleared", err, 0);
    chk("regen_after_err", ks_en, 1);
    drain("drain_after_err");
    chk("after_err_ks_cycles", ks_total - k0, 2);

`ifdef AES_DECRYPT_EN
    // Decrypt walks the key schedule backwards; encrypt afterwards resamples mode.
    issue(1'b0, 1'b1, t);
    push_block(t, 0, 1'b1);
    drain("drain_decrypt");
    chk("decrypt_sel_idle", sel_key, 0);
    issue(1'b0, 1'b0, t);
    push_block(t, 0, 1'b0);
    drain("drain_encrypt_again");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before time 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
